// File: rtl/trdb_branch_map.sv
// Branch-map accumulator: one bit per retired conditional branch (1 = not taken), 1-cycle latency.
// No backpressure: a branch arriving while full is dropped unless flushed the same cycle; TRDB_BRANCH_MAP_OVF_EN adds a sticky overflow flag.
module trdb_branch_map #(
    parameter int MAP_LEN = 31,
    parameter int CNT_W   = $clog2(MAP_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               is_branch_i,
    input  logic               is_branch_taken_i,
    input  logic               flush_i,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_W-1:0]   branches_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               overflow_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAP_LEN);

    logic [MAP_LEN-1:0] map_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br;
    logic               nb;
    logic               full;

    assign br   = valid_i & is_branch_i;
    assign nb   = ~is_branch_taken_i;
    assign full = (cnt_q == MAX_CNT);

    // A flush coinciding with a branch starts the next map with that branch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            if (br) begin
                map_q <= MAP_LEN'(nb);
                cnt_q <= CNT_W'(1);
            end else begin
                map_q <= '0;
                cnt_q <= '0;
            end
        end else if (br && !full) begin
            map_q[cnt_q] <= nb;
            cnt_q        <= cnt_q + CNT_W'(1);
        end
    end

`ifdef TRDB_BRANCH_MAP_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (br && !flush_i && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign is_full_o  = full;
    assign is_empty_o = (cnt_q == '0);

endmodule
